// File: rtl/fwd_ctrl.sv
// Forwarding and load-use interlock controller for the ID stage of a 5-stage MIPS pipeline.
// Define FWD_CTRL_FORWARD_EN for operand forwarding; otherwise the block is a pure interlock.
module fwd_ctrl (
  input  logic        clk,
  input  logic        clrn,
  input  logic        hold,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic        usert,
  input  logic [4:0]  rn,
  input  logic        wreg,
  input  logic        m2reg,
  output logic [1:0]  fwda,
  output logic [1:0]  fwdb,
  output logic        wpcir,
  output logic        bubble,
  output logic [15:0] stall_cnt
);

  logic [4:0]  ern_q, ern_d, mrn_q, mrn_d;
  logic        ewreg_q, ewreg_d, em2reg_q, em2reg_d;
  logic        mwreg_q, mwreg_d, mm2reg_q, mm2reg_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        ex_rs, ex_rt, mem_rs, mem_rt;
  logic        stall;

  // Register $0 is hard-wired, so a write to it is never a dependency.
  assign ex_rs  = ewreg_q && (ern_q != 5'd0) && (ern_q == rs);
  assign ex_rt  = ewreg_q && (ern_q != 5'd0) && (ern_q == rt);
  assign mem_rs = mwreg_q && (mrn_q != 5'd0) && (mrn_q == rs);
  assign mem_rt = mwreg_q && (mrn_q != 5'd0) && (mrn_q == rt);

`ifdef FWD_CTRL_FORWARD_EN
  always_comb begin
    fwda = 2'b00;
    fwdb = 2'b00;
    if (ex_rs && !em2reg_q) fwda = 2'b01;
    else if (mem_rs)        fwda = mm2reg_q ? 2'b11 : 2'b10;
    if (ex_rt && !em2reg_q) fwdb = 2'b01;
    else if (mem_rt)        fwdb = mm2reg_q ? 2'b11 : 2'b10;
  end

  // Only a load still in EX cannot be forwarded in time.
  assign stall = (ex_rs || (usert && ex_rt)) && em2reg_q;
`else
  logic unused_m2reg;

  assign fwda         = 2'b00;
  assign fwdb         = 2'b00;
  assign stall        = ex_rs || (usert && ex_rt) || mem_rs || (usert && mem_rt);
  assign unused_m2reg = em2reg_q ^ mm2reg_q;
`endif

  assign wpcir     = !(stall || hold);
  assign bubble    = stall && !hold;
  assign stall_cnt = stall_cnt_q;

  always_comb begin
    ern_d       = ern_q;
    ewreg_d     = ewreg_q;
    em2reg_d    = em2reg_q;
    mrn_d       = mrn_q;
    mwreg_d     = mwreg_q;
    mm2reg_d    = mm2reg_q;
    stall_cnt_d = stall_cnt_q;
    if (!hold) begin
      mrn_d    = ern_q;
      mwreg_d  = ewreg_q;
      mm2reg_d = em2reg_q;
      // A stalled instruction stays in ID while a nop enters EX.
      if (stall) begin
        ern_d    = 5'd0;
        ewreg_d  = 1'b0;
        em2reg_d = 1'b0;
        if (stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
      end else begin
        ern_d    = rn;
        ewreg_d  = wreg;
        em2reg_d = m2reg;
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ern_q       <= 5'd0;
      ewreg_q     <= 1'b0;
      em2reg_q    <= 1'b0;
      mrn_q       <= 5'd0;
      mwreg_q     <= 1'b0;
      mm2reg_q    <= 1'b0;
      stall_cnt_q <= 16'd0;
    end else begin
      ern_q       <= ern_d;
      ewreg_q     <= ewreg_d;
      em2reg_q    <= em2reg_d;
      mrn_q       <= mrn_d;
      mwreg_q     <= mwreg_d;
      mm2reg_q    <= mm2reg_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
